gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_check_pkg.sv | 21 ++
 rtl/hold_timer.sv | 30 +++
 rtl/gate_truth_checker.sv | 100 ++++++++++
 tb/tb_gate_truth_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared types and sizing for the two-input gate truth-table checker.
// Holds the FSM encoding, the pattern count and the result-counter width.
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_PATTERNS = 4;
  localparam int IDX_W        = 2;
  localparam int ERR_W        = 3;

  // Width of the hold counter; it only has to reach HOLD_CYCLES-2.
  function automatic int cnt_width(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Settle-phase timer: load restarts the count, tick advances it, expire flags
// the last settle cycle. The count saturates so it can never wrap mid-pattern.
module hold_timer
  import gate_check_pkg::*;
#(
  parameter int HOLD_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expire
);

  localparam int            CW   = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_cnt <= '0;
    end else if (tick && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expire = (r_cnt == LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives the four {a,b} patterns into a gate under test, samples its output once
// per pattern after a settle window and accumulates mismatches against EXPECTED.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int         HOLD_CYCLES = 50,
  parameter logic [3:0] EXPECTED    = 4'b0001
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    y_in,
  output logic                    a,
  output logic                    b,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_W-1:0]        err_count,
  output logic [NUM_PATTERNS-1:0] fail_vec,
  output state_t                  dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_W-1:0]        r_idx;
  logic [ERR_W-1:0]        r_err;
  logic [NUM_PATTERNS-1:0] r_fail;
  logic                    w_accept;
  logic                    w_load;
  logic                    w_tick;
  logic                    w_expire;

  // start is honoured only when no sweep is running
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_load   = w_accept || ((r_state == ST_CHECK) && (r_idx != LAST_IDX));
  assign w_tick   = (r_state == ST_SETTLE);

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .tick  (w_tick),
    .expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_next = ST_SETTLE;
      ST_SETTLE: if (w_expire) w_next = ST_CHECK;
      ST_CHECK:  w_next = (r_idx == LAST_IDX) ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (start) w_next = ST_SETTLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // y_in is looked at only on the edge that closes the single CHECK cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_err  <= '0;
      r_fail <= '0;
    end else if (w_accept) begin
      r_idx  <= '0;
      r_err  <= '0;
      r_fail <= '0;
    end else if (r_state == ST_CHECK) begin
      if (y_in != EXPECTED[r_idx]) begin
        r_fail[r_idx] <= 1'b1;
        r_err         <= r_err + ERR_W'(1);
      end
      if (r_idx != LAST_IDX) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    busy      = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    done      = (r_state == ST_DONE);
    {a, b}    = busy ? r_idx : 2'b00;
    pass      = done && (r_err == '0);
    err_count = r_err;
    fail_vec  = r_fail;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three instances (NOR/H=4, AND/H=4, XOR/H=2) share
// start and rst; each drives a bench-side gate and is compared every cycle to a timing model.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  localparam int ND = 3;

  typedef struct {
    logic       busy;
    logic       done;
    logic [1:0] ab;
    logic       pass;
    logic [2:0] err;
    logic [3:0] fv;
    state_t     st;
  } exp_t;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [ND-1:0] y_in, a, b, busy, done, pass;
  logic [2:0]    err_count [ND];
  logic [3:0]    fail_vec  [ND];
  state_t        dbg_state [ND];

  gate_truth_checker #(.HOLD_CYCLES(4), .EXPECTED(4'b0001)) u_nor (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in[0]), .a(a[0]), .b(b[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .fail_vec(fail_vec[0]), .dbg_state(dbg_state[0]));

  gate_truth_checker #(.HOLD_CYCLES(4), .EXPECTED(4'b1000)) u_and (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in[1]), .a(a[1]), .b(b[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .fail_vec(fail_vec[1]), .dbg_state(dbg_state[1]));

  gate_truth_checker #(.HOLD_CYCLES(2), .EXPECTED(4'b0110)) u_xor (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in[2]), .a(a[2]), .b(b[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err_count[2]),
    .fail_vec(fail_vec[2]), .dbg_state(dbg_state[2]));

  // ---------------- reference model state ----------------
  int         cyc;
  int         st_edge  [ND];  // edge at which the current sweep was accepted, -1 if none
  logic [3:0] tt       [ND];  // truth table of the bench-side gate
  logic [3:0] sweep_tt [ND];  // truth table in force for the accepted sweep
  bit         noise;
  int         n_vec;
  int         n_err;

  function automatic int hold_of(input int d);
    return (d == 2) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_of(input int d);
    case (d)
      0:       return 4'b0001;
      1:       return 4'b1000;
      default: return 4'b0110;
    endcase
  endfunction

  function automatic bit model_busy(input int d, input int t);
    return (st_edge[d] >= 0) && ((t - st_edge[d]) < 4 * hold_of(d));
  endfunction

  function automatic exp_t model(input int d, input int t);
    exp_t       e;
    int         h;
    int         off;
    int         ncomp;
    logic [3:0] want;
    h      = hold_of(d);
    want   = exp_of(d);
    e.busy = 1'b0; e.done = 1'b0; e.ab = 2'b00; e.pass = 1'b0;
    e.err  = 3'd0; e.fv = 4'b0000; e.st = ST_IDLE;
    if (st_edge[d] < 0) return e;
    off   = t - st_edge[d];
    ncomp = (off >= 4 * h) ? 4 : off / h;
    for (int j = 0; j < ncomp; j++) begin
      if (sweep_tt[d][j] != want[j]) begin
        e.fv[j] = 1'b1;
        e.err   = e.err + 3'd1;
      end
    end
    if (off < 4 * h) begin
      e.busy = 1'b1;
      e.ab   = 2'(off / h);
      e.st   = ((off % h) == h - 1) ? ST_CHECK : ST_SETTLE;
    end else begin
      e.done = 1'b1;
      e.pass = (e.err == 3'd0);
      e.st   = ST_DONE;
    end
    return e;
  endfunction

  function automatic bit any_busy();
    for (int d = 0; d < ND; d++) if (model_busy(d, cyc)) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: observed %0h expected %0h", tag, d, cyc, obs, expv);
      $error("%s miscompare on dut%0d", tag, d);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    bit   was_busy [ND];
    exp_t e;
    bit   in_chk;
    for (int d = 0; d < ND; d++) was_busy[d] = model_busy(d, cyc);
    @(posedge clk);
    cyc++;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        st_edge[d] = -1;
      end else if (start && !was_busy[d]) begin
        st_edge[d]  = cyc;
        sweep_tt[d] = tt[d];
      end
    end
    #1;
    for (int d = 0; d < ND; d++) begin
      e = model(d, cyc);
      chk("busy",      d, 8'(busy[d]),     8'(e.busy));
      chk("done",      d, 8'(done[d]),     8'(e.done));
      chk("ab",        d, 8'({a[d], b[d]}), 8'(e.ab));
      chk("pass",      d, 8'(pass[d]),     8'(e.pass));
      chk("err_count", d, 8'(err_count[d]), 8'(e.err));
      chk("fail_vec",  d, 8'(fail_vec[d]), 8'(e.fv));
      chk("state",     d, 8'(dbg_state[d]), 8'(e.st));
      // Gate output is meaningful only in the sampling cycle; elsewhere it may bounce.
      in_chk = (e.st == ST_CHECK);
      y_in[d] = (in_chk || !noise) ? tt[d][{a[d], b[d]}] : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; y_in = '0; noise = 1'b0;
    cyc = 0; n_vec = 0; n_err = 0;
    for (int d = 0; d < ND; d++) begin
      st_edge[d] = -1; tt[d] = 4'b0000; sweep_tt[d] = 4'b0000;
    end
    step(); step();
    rst = 1'b0;
    step();

    // matching gates on every instance: clean pass, done at N+4*H
    tt[0] = 4'b0001; tt[1] = 4'b1000; tt[2] = 4'b0110;
    pulse_start();
    repeat (18) step();

    // stuck-at-0 vs NOR, NAND vs AND, random vs XOR, with bouncing y_in in settle
    noise = 1'b1;
    tt[0] = 4'b0000; tt[1] = 4'b0111; tt[2] = 4'($urandom);
    pulse_start();
    repeat (18) step();

    // OR vs NOR: every pattern wrong; restart issued from DONE
    tt[0] = 4'b1110; tt[1] = 4'b1000;
    pulse_start();
    repeat (18) step();

    // start re-pulsed mid-sweep is ignored, then rst aborts the sweep
    tt[0] = 4'b0001;
    pulse_start();
    repeat (5) step();
    pulse_start();
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    pulse_start();
    repeat (18) step();

    // random traffic: tables change only while no sweep runs
    repeat (400) begin
      if (!any_busy() && ($urandom_range(0, 3) == 0)) begin
        for (int d = 0; d < ND; d++) tt[d] = 4'($urandom);
      end
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      step();
      start = 1'b0;
      rst   = 1'b0;
    end
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
